regfile_multiport: RTL

//  Next-generation pipeline register file. Parametrised read-port count, two write ports
//  (A = memory/load return, B = writeback). Write-to-read bypass and a per-register

---
 rtl/regfile_multiport.sv | 86 ++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Decode-stage register file: NUM_READ combinational read ports with write bypass, two write ports.
// Zero-latency reads; writes and busy-scoreboard updates land on CLK; RD_BUSY flags loads still outstanding.
module regfile_multiport #(
   parameter int SIZE       = 32,
   parameter int AMOUNT_REG = 4,
   parameter int NUM_READ   = 3,
   parameter int PC_REG     = 15
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           WE_A,
   input  logic [AMOUNT_REG-1:0]          WA_A,
   input  logic [SIZE-1:0]                WD_A,
   input  logic                           WE_B,
   input  logic [AMOUNT_REG-1:0]          WA_B,
   input  logic [SIZE-1:0]                WD_B,
   input  logic [NUM_READ*AMOUNT_REG-1:0] RA,
   input  logic [SIZE-1:0]                R15,
   input  logic                           BUSY_SET,
   input  logic [AMOUNT_REG-1:0]          BUSY_ADDR,
   output logic [NUM_READ*SIZE-1:0]       RD,
   output logic [NUM_READ-1:0]            RD_BUSY,
   output logic [2**AMOUNT_REG-1:0]       BUSY_VEC
);

   localparam int NREG = 2**AMOUNT_REG;
   localparam logic [AMOUNT_REG-1:0] PC_ADDR = AMOUNT_REG'(PC_REG);

   logic [SIZE-1:0] rf_q [NREG];
   logic [SIZE-1:0] rf_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            we_a;
   logic            we_b;
   logic            busy_set;

   // Reset blocks writes and bypass alike; the PC is never stored.
   assign we_a     = WE_A && !RST && (WA_A != PC_ADDR);
   assign we_b     = WE_B && !RST && (WA_B != PC_ADDR);
   assign busy_set = BUSY_SET && !RST && (BUSY_ADDR != PC_ADDR);

   always_comb begin
      rf_d = rf_q;
      if (we_a) rf_d[WA_A] = WD_A;
      if (we_b) rf_d[WA_B] = WD_B;
   end

   // A new load issued in the same cycle its predecessor returns stays outstanding.
   always_comb begin
      busy_d = busy_q;
      if (we_a)     busy_d[WA_A]      = 1'b0;
      if (we_b)     busy_d[WA_B]      = 1'b0;
      if (busy_set) busy_d[BUSY_ADDR] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int n = 0; n < NREG; n++) rf_q[n] <= '0;
         busy_q <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
      end
   end

   assign BUSY_VEC = busy_q;

   for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
      logic [AMOUNT_REG-1:0] ra;
      logic                  hit_a;
      logic                  hit_b;
      logic                  is_pc;

      assign ra    = RA[g*AMOUNT_REG +: AMOUNT_REG];
      assign is_pc = (ra == PC_ADDR);
      assign hit_a = we_a && (WA_A == ra);
      assign hit_b = we_b && (WA_B == ra);

      assign RD[g*SIZE +: SIZE] = is_pc ? R15  :
                                  hit_b ? WD_B :
                                  hit_a ? WD_A : rf_q[ra];

      assign RD_BUSY[g] = busy_q[ra] && !hit_a && !hit_b && !is_pc;
   end

endmodule
